// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control unit: datapath element
// indices, opcode encodings, IR field positions and the sequencer state enum.
package cpu_ctrl_pkg;

  // Datapath element indices (bit position in enable / busSelect)
  localparam logic [4:0] EL_R0     = 5'd0;
  localparam logic [4:0] EL_HI     = 5'd16;
  localparam logic [4:0] EL_LO     = 5'd17;
  localparam logic [4:0] EL_ZLO    = 5'd18;
  localparam logic [4:0] EL_ZHI    = 5'd19;
  localparam logic [4:0] EL_PC     = 5'd20;
  localparam logic [4:0] EL_MDR    = 5'd21;
  localparam logic [4:0] EL_INPORT = 5'd22;
  localparam logic [4:0] EL_IR     = 5'd23;
  localparam logic [4:0] EL_Z      = 5'd24;
  localparam logic [4:0] EL_MAR    = 5'd25;
  localparam logic [4:0] EL_Y      = 5'd26;

  // Opcode encodings
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // IR field positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  // One-hot mask selecting a single datapath element
  function automatic logic [31:0] onehot(input logic [4:0] idx);
    onehot = 32'd1 << idx;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode classifier: exactly one class flag is high for any opcode.
module instr_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output logic       is_alu,
  output logic       is_unary,
  output logic       is_muldiv,
  output logic       is_nop,
  output logic       is_halt,
  output logic       is_illegal
);

  // Classify the opcode into the execute-sequence family it uses
  always_comb begin
    is_alu     = 1'b0;
    is_unary   = 1'b0;
    is_muldiv  = 1'b0;
    is_nop     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL:       is_alu     = 1'b1;
      OP_NEG, OP_NOT:                        is_unary   = 1'b1;
      OP_MUL, OP_DIV:                        is_muldiv  = 1'b1;
      OP_NOP:                                is_nop     = 1'b1;
      OP_HALT:                               is_halt    = 1'b1;
      default:                               is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the single-bus datapath.
// Fetch runs T0-T2, execute runs T3-T6 depending on the instruction class.
// Build option: CU_ILLEGAL_TRAP_EN makes an undefined opcode trap into HALT
// (no retire) instead of behaving as a NOP with an illegal pulse.
// state_dbg exposes the present FSM state for observation.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int IR_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [IR_W-1:0]  ir,
  output logic [31:0]      enable,
  output logic [31:0]      busSelect,
  output logic             MR_Read,
  output logic [4:0]       alu_op,
  output logic             inc_pc,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state_dbg
);

  state_t state, next_state;
  logic   retire;
  logic   is_alu, is_unary, is_muldiv, is_nop, is_halt, is_illegal;

  logic [4:0] ra_el, rb_el, rc_el;
  logic       ir_low_unused;

  assign ra_el = {1'b0, ir[RA_MSB:RA_LSB]};
  assign rb_el = {1'b0, ir[RB_MSB:RB_LSB]};
  assign rc_el = {1'b0, ir[RC_MSB:RC_LSB]};
  assign ir_low_unused = ^ir[RC_LSB-1:0];

  instr_decode u_decode (
    .opcode     (ir[OPC_MSB:OPC_LSB]),
    .is_alu     (is_alu),
    .is_unary   (is_unary),
    .is_muldiv  (is_muldiv),
    .is_nop     (is_nop),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  // State register; clr forces IDLE asynchronously
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= S_IDLE;
    else      state <= next_state;
  end

  // Next-state and per-state control decode
  always_comb begin
    next_state = state;
    enable     = 32'd0;
    busSelect  = 32'd0;
    MR_Read    = 1'b0;
    inc_pc     = 1'b0;
    illegal    = 1'b0;
    retire     = 1'b0;
    case (state)
      S_IDLE: if (run) next_state = S_T0;
      S_T0: begin
        busSelect  = onehot(EL_PC);
        enable     = onehot(EL_MAR) | onehot(EL_Z);
        inc_pc     = 1'b1;
        next_state = S_T1;
      end
      S_T1: begin
        busSelect  = onehot(EL_ZLO);
        enable     = onehot(EL_PC) | onehot(EL_MDR);
        MR_Read    = 1'b1;
        next_state = S_T2;
      end
      S_T2: begin
        busSelect  = onehot(EL_MDR);
        enable     = onehot(EL_IR);
        next_state = S_T3;
      end
      S_T3: begin
        if (is_alu) begin
          busSelect  = onehot(rb_el);
          enable     = onehot(EL_Y);
          next_state = S_T4;
        end else if (is_unary) begin
          busSelect  = onehot(rb_el);
          enable     = onehot(EL_Z);
          next_state = S_T4;
        end else if (is_muldiv) begin
          busSelect  = onehot(ra_el);
          enable     = onehot(EL_Y);
          next_state = S_T4;
        end else if (is_halt) begin
          retire     = 1'b1;
          next_state = S_HALT;
        end else if (is_nop) begin
          retire     = 1'b1;
          next_state = run ? S_T0 : S_IDLE;
        end else if (is_illegal) begin
          illegal    = 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
          next_state = S_HALT;
`else
          retire     = 1'b1;
          next_state = run ? S_T0 : S_IDLE;
`endif
        end else begin
          next_state = S_IDLE;
        end
      end
      S_T4: begin
        if (is_alu) begin
          busSelect  = onehot(rc_el);
          enable     = onehot(EL_Z);
          next_state = S_T5;
        end else if (is_unary) begin
          busSelect  = onehot(EL_ZLO);
          enable     = onehot(ra_el);
          retire     = 1'b1;
          next_state = run ? S_T0 : S_IDLE;
        end else if (is_muldiv) begin
          busSelect  = onehot(rb_el);
          enable     = onehot(EL_Z);
          next_state = S_T5;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_T5: begin
        if (is_alu) begin
          busSelect  = onehot(EL_ZLO);
          enable     = onehot(ra_el);
          retire     = 1'b1;
          next_state = run ? S_T0 : S_IDLE;
        end else if (is_muldiv) begin
          busSelect  = onehot(EL_ZLO);
          enable     = onehot(EL_LO);
          next_state = S_T6;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_T6: begin
        busSelect  = onehot(EL_ZHI);
        enable     = onehot(EL_HI);
        retire     = 1'b1;
        next_state = run ? S_T0 : S_IDLE;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

  // ALU opcode is presented whenever Z is loading
  assign alu_op    = enable[EL_Z] ? ir[OPC_MSB:OPC_LSB] : 5'd0;
  assign halted    = (state == S_HALT);
  assign state_dbg = state;

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)        instr_count <= '0;
    else if (retire) instr_count <= instr_count + 1'b1;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that drives the single-bus datapath with per-cycle register enables, bus-source selects, memory-read strobe and ALU opcode. It sits directly upstream of the datapath and consumes only the IR contents fed back from it. It steps fetch states T0–T2, then instruction-dependent execute states T3–T6, for register ALU, unary and multiply/divide instructions.

## Interface
- `IR_W`, 32: instruction register width
- `CNT_W`, 16: retired-instruction counter width
- `clk` in 1: system clock
- `clr` in 1: asynchronous, active-low reset
- `run` in 1: level; high lets the sequencer leave IDLE and continue fetching
- `ir` in IR_W: current IR contents from the datapath
- `enable` out 32: multi-hot register load enables; bit k loads element k
- `busSelect` out 32: one-hot bus source select; bit k drives element k onto the bus
- `MR_Read` out 1: memory read; MDR loads from MDataIn
- `alu_op` out 5: ALU operation, equal to `ir[31:27]` while Z loads, else 0
- `inc_pc` out 1: ALU computes PC+1 (asserted with Z load in T0)
- `halted` out 1: high in HALT state
- `illegal` out 1: one-cycle pulse on an undefined opcode
- `instr_count` out CNT_W: retired instructions

## Operation
- Element indices: R0–R15 = 0–15, HI 16, LO 17, ZLO 18, ZHI 19, PC 20, MDR 21, INPORT 22, IR 23, Z 24, MAR 25, Y 26.
- Fields: opcode `ir[31:27]`, Ra `ir[26:23]`, Rb `ir[22:19]`, Rc `ir[18:15]`.
- Opcodes: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHRA 01000, SHL 01001, ROR 01010, ROL 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010, NOP 11010, HALT 11011.
- States: IDLE, T0–T6, HALT.
- IDLE: all outputs 0; go to T0 when `run`=1.
- T0: busSelect PC; enable MAR, Z; inc_pc.
- T1: busSelect ZLO; enable PC, MDR; MR_Read.
- T2: busSelect MDR; enable IR.
- Binary ALU ops:
  - T3: bus Rb, enable Y.
  - T4: bus Rc, enable Z, alu_op.
  - T5: bus ZLO, enable Ra; retire.
- NEG/NOT:
  - T3: bus Rb, enable Z, alu_op.
  - T4: bus ZLO, enable Ra; retire.
- MUL/DIV:
  - T3: bus Ra, enable Y.
  - T4: bus Rb, enable Z, alu_op.
  - T5: bus ZLO, enable LO.
  - T6: bus ZHI, enable HI; retire.
- NOP: T3 has no outputs; retire.
- HALT: T3 retires, then enters HALT.
- Retire state exits to T0 if `run`=1, else to IDLE.
- HALT is exited only by reset.
- Undefined opcode:
  - T3 pulses `illegal` and retires as NOP.
  - See Configuration for the trap variant.
- `instr_count` increments by 1 on each retire edge and wraps from all-ones to 0.
- Ra = Rb = Rc is legal; the sequence is unchanged.

## Timing
- Reset: `clr` low forces IDLE immediately, independent of `clk`. All outputs go to 0, including `instr_count`. Reset mid-instruction abandons it without retiring.
- State register updates on the rising `clk` edge.
- Outputs are combinational decodes of present state and `ir`, stable for the whole state cycle.
- IR loads on the edge leaving T2, so T3 decodes the new instruction.
- Latency from T0 to retire: ALU ops 6 cycles, NEG/NOT 5, MUL/DIV 7, NOP/HALT 4.
- `run` is sampled only in IDLE and on retire states. Dropping `run` mid-instruction completes that instruction.
- `busSelect` is never multi-hot. It is all-zero in IDLE, HALT and NOP T3.

## Configuration
- `CU_ILLEGAL_TRAP_EN` defined: an undefined opcode pulses `illegal` in T3, then enters HALT without retiring. `instr_count` is not incremented.
- `CU_ILLEGAL_TRAP_EN` undefined: an undefined opcode behaves as NOP with an `illegal` pulse.

## Structure
- Shared package `cpu_ctrl_pkg`:
  - element index constants
  - opcode constants
  - state enum
  - IR field position constants
- One sub-module `instr_decode`: combinational classification of opcode into ALU/unary/muldiv/nop/halt/illegal.

## Test plan
- Reset: `clr` low mid-T4, then high with `run`=0 -> state IDLE, all outputs 0, `instr_count`=0.
- SHRA: `ir`=0x40090000, `run`=1.
  - T3: busSelect bit 1, enable bit 26.
  - T4: busSelect bit 2, enable bit 24, alu_op=01000.
  - T5: busSelect bit 18, enable bit 0.
  - Then T0, count 1.
- MUL: `ir`=0x78900000 (MUL R1,R2) -> T5 enable LO (bit 17), T6 busSelect ZHI (bit 19) with enable HI (bit 16), then retire.
- Fetch check:
  - T0: busSelect bit 20, enable bits 25 and 24, inc_pc.
  - T1: MR_Read, enable bits 20 and 21.
  - T2: enable bit 23.
- HALT `ir`=0xD8000000 -> `halted`=1, no further fetch with `run`=1; only reset clears it.
- Illegal `ir`=0xF8000000:
  - Without the macro: `illegal` pulse, count+1, fetch resumes.
  - With `CU_ILLEGAL_TRAP_EN`: `illegal` pulse, HALT, count unchanged.
